// File: rtl/multibank_ram_pkg.sv
// Shared constants and helpers for the multibank RAM arbiter.
// Latency: none (compile-time only).
// Backpressure: n/a.
// Contents: default parameter values, idx_w() index-width helper.
package multibank_ram_pkg;

  localparam int na_def  = 16;
  localparam int nd_def  = 16;
  localparam int nrp_def = 3;
  localparam int nwp_def = 3;
  localparam int nbl_def = 2;

  // Width of an index over n items; never zero so it can size a vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multibank_ram_arb_if.sv
// Request/response bundle between requesters and the multibank RAM.
// Latency: n/a (wires only).
// Backpressure: r_aready / w_ready driven by the slave each cycle.
// master: drives addresses, write data and valids; slave: drives readies and read data.
interface multibank_ram_arb_if
  import multibank_ram_pkg::*;
#(
  parameter int na  = na_def,
  parameter int nd  = nd_def,
  parameter int nrp = nrp_def,
  parameter int nwp = nwp_def
) ();

  logic [nrp*na-1:0] r_addr;
  logic [nrp-1:0]    r_avalid;
  logic [nrp-1:0]    r_aready;
  logic [nrp*nd-1:0] r_data;
  logic [nrp-1:0]    r_dvalid;
  logic [nwp*na-1:0] w_addr;
  logic [nwp*nd-1:0] w_data;
  logic [nwp-1:0]    w_valid;
  logic [nwp-1:0]    w_ready;

  modport master (
    output r_addr, r_avalid, w_addr, w_data, w_valid,
    input  r_aready, r_data, r_dvalid, w_ready
  );

  modport slave (
    input  r_addr, r_avalid, w_addr, w_data, w_valid,
    output r_aready, r_data, r_dvalid, w_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among n requesters, search starts at ptr.
// Latency: grant is combinational from req and ptr; ptr updates on the clock edge.
// Backpressure: non-granted requesters simply see gnt=0; ptr holds when nothing is granted.
// Ports: clk, reset (sync, active-high), req[n] in, gnt[n] out.
module rr_arbiter
  import multibank_ram_pkg::*;
#(
  parameter int n = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] req,
  output logic [n-1:0] gnt
);

  localparam int pw = idx_w(n);

  logic [pw-1:0] ptr;
  logic [pw-1:0] nxt;
  logic [pw-1:0] k;
  logic          found;
  int            kk;

  always_comb begin
    gnt   = '0;
    nxt   = ptr;
    found = 1'b0;
    k     = '0;
    kk    = 0;
    for (int i = 0; i < n; i++) begin
      kk = int'(ptr) + i;
      if (kk >= n) kk = kk - n;
      k = pw'(kk);
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        // Priority moves to the requester just after the winner.
        nxt    = (kk == n - 1) ? '0 : pw'(kk + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else if (found) ptr <= nxt;
  end

endmodule

// File: rtl/multibank_ram_arb.sv
// Multi-port RAM split into 2**nbl single-port banks, each with its own round-robin arbiter.
// Latency: ready is combinational; read data returns exactly one cycle after accept.
// Backpressure: losing requesters see ready=0 and may hold or change their request.
// Ports: clk, reset (sync, active-high), bus (slave side of multibank_ram_arb_if).
module multibank_ram_arb
  import multibank_ram_pkg::*;
#(
  parameter int na  = na_def,
  parameter int nd  = nd_def,
  parameter int nrp = nrp_def,
  parameter int nwp = nwp_def,
  parameter int nbl = nbl_def
) (
  input  logic                clk,
  input  logic                reset,
  multibank_ram_arb_if.slave  bus
);

  localparam int nb = 1 << nbl;
  localparam int n  = nwp + nrp;
  localparam int bw = (nbl > 0) ? nbl : 1;
  localparam int rw = na - nbl;
  localparam logic [na-1:0] bmask = na'((1 << nbl) - 1);

  // Requesters are numbered writes first, then reads.
  logic [n-1:0][na-1:0] req_addr;
  logic [n-1:0][nd-1:0] req_wdat;
  logic [n-1:0][bw-1:0] req_bank;
  logic [n-1:0]         req_vld;
  logic [n-1:0]         req_wr;

  always_comb begin
    req_addr = '0;
    req_wdat = '0;
    req_bank = '0;
    req_vld  = '0;
    req_wr   = '0;
    for (int j = 0; j < nwp; j++) begin
      req_addr[j] = bus.w_addr[j*na +: na];
      req_wdat[j] = bus.w_data[j*nd +: nd];
      req_vld[j]  = bus.w_valid[j];
      req_wr[j]   = 1'b1;
    end
    for (int i = 0; i < nrp; i++) begin
      req_addr[nwp+i] = bus.r_addr[i*na +: na];
      req_vld[nwp+i]  = bus.r_avalid[i];
    end
    for (int k = 0; k < n; k++) req_bank[k] = bw'(req_addr[k] & bmask);
  end

  logic [nb-1:0][n-1:0]  gnt_all;
  logic [nb-1:0][nd-1:0] bank_rdq;

  for (genvar b = 0; b < nb; b++) begin : g_bank
    logic [n-1:0]  req;
    logic          en;
    logic          we;
    logic [rw-1:0] row;
    logic [nd-1:0] wd;
    logic [nd-1:0] rdq;
    logic [nd-1:0] mem [1 << rw];

    always_comb begin
      req = '0;
      for (int k = 0; k < n; k++)
        req[k] = req_vld[k] && (req_bank[k] == bw'(b)) && !reset;
    end

    rr_arbiter #(.n(n)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .gnt   (gnt_all[b])
    );

    // Steer the single winner onto the bank's one access port.
    always_comb begin
      en  = |gnt_all[b];
      we  = 1'b0;
      row = '0;
      wd  = '0;
      for (int k = 0; k < n; k++) begin
        if (gnt_all[b][k]) begin
          row = rw'(req_addr[k] >> nbl);
          we  = req_wr[k];
          wd  = req_wdat[k];
        end
      end
    end

    // Read-first: a read returns the word as it was before this edge.
    always_ff @(posedge clk) begin
      if (en) begin
        if (we) mem[row] <= wd;
        rdq <= mem[row];
      end
    end

    assign bank_rdq[b] = rdq;
  end

  logic [n-1:0] rdy;

  always_comb begin
    rdy = '0;
    for (int b = 0; b < nb; b++) rdy = rdy | gnt_all[b];
  end

  assign bus.w_ready  = rdy[nwp-1:0];
  assign bus.r_aready = rdy[n-1:nwp];

  // Per read port: remember which bank answers, and keep the last word for hold.
  logic [nrp-1:0]         dv_q;
  logic [nrp-1:0][bw-1:0] bank_q;
  logic [nrp-1:0][nd-1:0] hold_q;
  logic [nrp-1:0][nd-1:0] rdat;

  always_ff @(posedge clk) begin
    if (reset) begin
      dv_q   <= '0;
      bank_q <= '0;
      hold_q <= '0;
    end else begin
      for (int i = 0; i < nrp; i++) begin
        dv_q[i]   <= rdy[nwp+i];
        bank_q[i] <= req_bank[nwp+i];
        if (dv_q[i]) hold_q[i] <= bank_rdq[bank_q[i]];
      end
    end
  end

  // Reset masks a read accepted just before it, and forces data to zero.
  always_comb begin
    rdat = '0;
    for (int i = 0; i < nrp; i++)
      if (!reset) rdat[i] = dv_q[i] ? bank_rdq[bank_q[i]] : hold_q[i];
  end

  assign bus.r_data   = rdat;
  assign bus.r_dvalid = dv_q & {nrp{!reset}};

endmodule

// File: tb/tb_multibank_ram_arb.sv
module tb_multibank_ram_arb;

  localparam int na = 16, nd = 16, nrp = 3, nwp = 3, nq = 6, nvec = 21, ncyc = 300;

  logic clk;
  int   total = 0;
  int   bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Directed instance, nbl=2
  logic rst_d;
  multibank_ram_arb_if #(.na(na), .nd(nd), .nrp(nrp), .nwp(nwp)) dif ();
  multibank_ram_arb #(.na(na), .nd(nd), .nrp(nrp), .nwp(nwp), .nbl(2)) dut_d (
    .clk   (clk),
    .reset (rst_d),
    .bus   (dif)
  );

  // Random instances, nbl = 0, 1, 2
  logic [2:0]        rrst;
  logic [2:0][2:0]   rwv, rrv, rwr, rrr, rdv;
  logic [2:0][47:0]  rwa, rwd, rra, rrd;

  for (genvar g = 0; g < 3; g++) begin : gr
    multibank_ram_arb_if #(.na(na), .nd(nd), .nrp(nrp), .nwp(nwp)) rb ();
    assign rb.w_valid  = rwv[g];
    assign rb.w_addr   = rwa[g];
    assign rb.w_data   = rwd[g];
    assign rb.r_avalid = rrv[g];
    assign rb.r_addr   = rra[g];
    assign rwr[g]      = rb.w_ready;
    assign rrr[g]      = rb.r_aready;
    assign rdv[g]      = rb.r_dvalid;
    assign rrd[g]      = rb.r_data;
    multibank_ram_arb #(.na(na), .nd(nd), .nrp(nrp), .nwp(nwp), .nbl(g)) dut (
      .clk   (clk),
      .reset (rrst[g]),
      .bus   (rb)
    );
  end

  typedef struct {
    logic        rst;
    logic [2:0]  wv;
    logic [47:0] wa;
    logic [47:0] wd;
    logic [2:0]  rv;
    logic [47:0] ra;
    logic [2:0]  ewr;
    logic [2:0]  err;
    logic [2:0]  edv;
    logic [47:0] erd;
  } vec_t;

  vec_t vt [nvec];

  // Reference model state for the random phase
  logic [15:0] mm   [3][16];
  bit          act  [3][6];
  int          wt   [3][6];
  logic [15:0] aad  [3][6];
  logic [15:0] adt  [3][6];
  bit          pend [3][3];
  logic [15:0] expd [3][3];
  logic [15:0] last [3][3];
  bit          gt   [6];
  int          gc   [4];
  int          vc   [4];
  logic        rdy;
  int          bk;
  logic [15:0] d16;
  logic [15:0] got16;

  initial begin
    // rst, wv, wa, wd, rv, ra, exp w_ready, exp r_aready, exp r_dvalid, exp r_data
    vt[0]  = '{1, 3'b001, {32'h0,16'h0005}, {32'h0,16'hA5A5}, 3'b001, {32'h0,16'h0005}, 3'b000, 3'b000, 3'b000, 48'h0};
    vt[1]  = '{0, 3'b011, {16'h0,16'h0013,16'h0005}, {16'h0,16'h1313,16'hA5A5}, 3'b000, 48'h0, 3'b011, 3'b000, 3'b000, 48'h0};
    vt[2]  = '{0, 3'b000, 48'h0, 48'h0, 3'b001, {32'h0,16'h0005}, 3'b000, 3'b001, 3'b000, 48'h0};
    vt[3]  = '{0, 3'b000, 48'h0, 48'h0, 3'b000, 48'h0, 3'b000, 3'b000, 3'b001, {32'h0,16'hA5A5}};
    vt[4]  = '{0, 3'b000, 48'h0, 48'h0, 3'b000, 48'h0, 3'b000, 3'b000, 3'b000, {32'h0,16'hA5A5}};
    vt[5]  = '{1, 3'b000, 48'h0, 48'h0, 3'b000, 48'h0, 3'b000, 3'b000, 3'b000, 48'h0};
    vt[6]  = '{0, 3'b011, {16'h0,16'h0101,16'h0001}, {16'h0,16'h2000,16'h1000}, 3'b001, {32'h0,16'h0005}, 3'b001, 3'b000, 3'b000, 48'h0};
    vt[7]  = '{0, 3'b011, {16'h0,16'h0101,16'h0001}, {16'h0,16'h2000,16'h1000}, 3'b001, {32'h0,16'h0005}, 3'b010, 3'b000, 3'b000, 48'h0};
    vt[8]  = '{0, 3'b011, {16'h0,16'h0101,16'h0001}, {16'h0,16'h2000,16'h1000}, 3'b001, {32'h0,16'h0005}, 3'b000, 3'b001, 3'b000, 48'h0};
    vt[9]  = '{0, 3'b011, {16'h0,16'h0101,16'h0001}, {16'h0,16'h2000,16'h1000}, 3'b001, {32'h0,16'h0005}, 3'b001, 3'b000, 3'b001, {32'h0,16'hA5A5}};
    vt[10] = '{0, 3'b011, {16'h0,16'h0101,16'h0001}, {16'h0,16'h2000,16'h1000}, 3'b001, {32'h0,16'h0005}, 3'b010, 3'b000, 3'b000, {32'h0,16'hA5A5}};
    vt[11] = '{0, 3'b011, {16'h0,16'h0101,16'h0001}, {16'h0,16'h2000,16'h1000}, 3'b001, {32'h0,16'h0005}, 3'b000, 3'b001, 3'b000, {32'h0,16'hA5A5}};
    vt[12] = '{0, 3'b111, {16'h0012,16'h0011,16'h0010}, {16'h0B02,16'h0B01,16'h0B00}, 3'b001, {32'h0,16'h0013}, 3'b111, 3'b001, 3'b001, {32'h0,16'hA5A5}};
    vt[13] = '{1, 3'b001, {32'h0,16'h0005}, {32'h0,16'hDEAD}, 3'b000, 48'h0, 3'b000, 3'b000, 3'b000, 48'h0};
    vt[14] = '{0, 3'b001, {32'h0,16'h0020}, {32'h0,16'h1111}, 3'b001, {32'h0,16'h0020}, 3'b001, 3'b000, 3'b000, 48'h0};
    vt[15] = '{0, 3'b000, 48'h0, 48'h0, 3'b001, {32'h0,16'h0020}, 3'b000, 3'b001, 3'b000, 48'h0};
    vt[16] = '{0, 3'b000, 48'h0, 48'h0, 3'b001, {32'h0,16'h0005}, 3'b000, 3'b001, 3'b001, {32'h0,16'h1111}};
    vt[17] = '{0, 3'b000, 48'h0, 48'h0, 3'b000, 48'h0, 3'b000, 3'b000, 3'b001, {32'h0,16'hA5A5}};
    vt[18] = '{0, 3'b000, 48'h0, 48'h0, 3'b111, {16'h0013,16'h0001,16'h0101}, 3'b000, 3'b110, 3'b000, {32'h0,16'hA5A5}};
    vt[19] = '{0, 3'b000, 48'h0, 48'h0, 3'b001, {32'h0,16'h0101}, 3'b000, 3'b001, 3'b110, {16'h1313,16'h1000,16'hA5A5}};
    vt[20] = '{0, 3'b000, 48'h0, 48'h0, 3'b000, 48'h0, 3'b000, 3'b000, 3'b001, {16'h1313,16'h1000,16'h2000}};

    rst_d = 1'b1;
    dif.w_valid = '0; dif.w_addr = '0; dif.w_data = '0;
    dif.r_avalid = '0; dif.r_addr = '0;
    rrst = '1;
    rwv = '0; rrv = '0; rwa = '0; rwd = '0; rra = '0;

    @(posedge clk); #1;
    for (int i = 0; i < nvec; i++) begin
      rst_d        = vt[i].rst;
      dif.w_valid  = vt[i].wv;
      dif.w_addr   = vt[i].wa;
      dif.w_data   = vt[i].wd;
      dif.r_avalid = vt[i].rv;
      dif.r_addr   = vt[i].ra;
      @(negedge clk);
      chk($sformatf("v%0d_w_ready", i),  64'(dif.w_ready),  64'(vt[i].ewr));
      chk($sformatf("v%0d_r_aready", i), 64'(dif.r_aready), 64'(vt[i].err));
      chk($sformatf("v%0d_r_dvalid", i), 64'(dif.r_dvalid), 64'(vt[i].edv));
      chk($sformatf("v%0d_r_data", i),   64'(dif.r_data),   64'(vt[i].erd));
      @(posedge clk); #1;
    end
    dif.w_valid = '0; dif.r_avalid = '0;

    // Random phase: release reset, preload all 16 pool words through w0.
    rrst = '0;
    for (int a = 0; a < 16; a++) begin
      for (int g = 0; g < 3; g++) begin
        d16 = 16'($urandom);
        rwv[g] = 3'b001;
        rwa[g] = {32'h0, 16'(a)};
        rwd[g] = {32'h0, d16};
        mm[g][a] = d16;
      end
      @(negedge clk);
      for (int g = 0; g < 3; g++) chk($sformatf("pre_a%0d_nbl%0d", a, g), 64'(rwr[g]), 64'h1);
      @(posedge clk); #1;
    end
    rwv = '0;
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < nq; k++) begin act[g][k] = 0; wt[g][k] = 0; end
      for (int i = 0; i < 3; i++) begin pend[g][i] = 0; last[g][i] = '0; expd[g][i] = '0; end
    end

    for (int cyc = 0; cyc < ncyc; cyc++) begin
      // Requests are held until granted, otherwise re-rolled each cycle.
      for (int g = 0; g < 3; g++) begin
        for (int k = 0; k < nq; k++) begin
          if (!act[g][k] && $urandom_range(0, 9) < 6) begin
            act[g][k] = 1;
            aad[g][k] = 16'($urandom_range(0, 15));
            adt[g][k] = 16'($urandom);
          end
          if (k < 3) begin
            rwv[g][k] = act[g][k];
            rwa[g][k*16 +: 16] = aad[g][k];
            rwd[g][k*16 +: 16] = adt[g][k];
          end else begin
            rrv[g][k-3] = act[g][k];
            rra[g][(k-3)*16 +: 16] = aad[g][k];
          end
        end
      end

      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        for (int b = 0; b < 4; b++) begin gc[b] = 0; vc[b] = 0; end
        for (int k = 0; k < nq; k++) begin
          rdy = (k < 3) ? rwr[g][k] : rrr[g][k-3];
          bk  = int'(aad[g][k]) & ((1 << g) - 1);
          chk($sformatf("c%0d_nbl%0d_rq%0d_ready_without_valid", cyc, g, k), 64'(rdy & !act[g][k]), 64'h0);
          gt[k] = act[g][k] && rdy;
          if (act[g][k]) begin
            vc[bk]++;
            if (rdy) gc[bk]++;
          end
        end
        for (int b = 0; b < (1 << g); b++)
          chk($sformatf("c%0d_nbl%0d_bank%0d_grants", cyc, g, b), 64'(gc[b]), 64'((vc[b] > 0) ? 1 : 0));
        // Reads see memory as it was before this cycle's writes.
        for (int i = 0; i < 3; i++) begin
          if (gt[3+i]) begin
            pend[g][i] = 1;
            expd[g][i] = mm[g][aad[g][3+i]];
          end
        end
        for (int k = 0; k < 3; k++) if (gt[k]) mm[g][aad[g][k]] = adt[g][k];
        for (int k = 0; k < nq; k++) begin
          if (gt[k]) begin
            act[g][k] = 0;
            wt[g][k]  = 0;
          end else if (act[g][k]) begin
            wt[g][k]++;
            chk($sformatf("c%0d_nbl%0d_rq%0d_starved", cyc, g, k), 64'(wt[g][k] >= nq), 64'h0);
            if (wt[g][k] >= nq) begin act[g][k] = 0; wt[g][k] = 0; end
          end
        end
      end

      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) begin
        for (int i = 0; i < 3; i++) begin
          got16 = rrd[g][i*16 +: 16];
          chk($sformatf("c%0d_nbl%0d_r%0d_dvalid", cyc, g, i), 64'(rdv[g][i]), 64'(pend[g][i]));
          if (pend[g][i]) begin
            chk($sformatf("c%0d_nbl%0d_r%0d_data", cyc, g, i), 64'(got16), 64'(expd[g][i]));
            last[g][i] = expd[g][i];
          end else begin
            chk($sformatf("c%0d_nbl%0d_r%0d_hold", cyc, g, i), 64'(got16), 64'(last[g][i]));
          end
          pend[g][i] = 0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
